// File: rtl/dual_port_byte_mem.sv
// dual_port_byte_mem: byte-addressed, little-endian dual-port data RAM shared by the
// core (port A) and the client (port B). Each port does byte, half or word accesses
// with zero or sign extension on reads. Misaligned accesses can optionally be rejected.
// A clear engine can optionally sweep the array to zero after reset.
//
// Ports:
//   Clk, Rst            rising-edge clock, asynchronous active-high reset
//   busy                clear sweep in progress
//   x_req / x_we        request strobe (sampled while x_ready) / write select
//   x_size              1 byte, 2 half, 3 word, 0 illegal
//   x_signed            sign-extend read data
//   x_addr / x_wdata    lowest byte address / write data (byte k -> addr+k)
//   x_ready             port accepts requests
//   x_rvalid / x_rdata  one-cycle read-valid pulse / extended read data (held)
//   x_err               one-cycle pulse for a rejected request
module dual_port_byte_mem #(
    parameter int unsigned ADDR_W       = 16,
    parameter bit          CLEAR_ON_RST = 1'b1,
    parameter bit          ALIGN_CHECK  = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              busy,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_size,
    input  logic              a_signed,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_size,
    input  logic              b_signed,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,
    output logic              b_err
);

    localparam int unsigned CNT_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clear_c;
    logic             ready_q;

    logic [7:0] mem [DEPTH];

    // Request is rejected: illegal size, or misaligned half/word when checking is on.
    function automatic logic illegal(input logic [1:0] size, input logic [1:0] low);
        return (size == 2'd0) ||
               (ALIGN_CHECK && (((size == 2'd2) && low[0]) ||
                                ((size == 2'd3) && (low != 2'b00))));
    endfunction

    // Byte lanes touched by an access of the given size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Extend the raw little-endian bytes to 32 bits; words ignore sgn.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            2'd1:    return {{24{sgn & raw[7]}}, raw[7:0]};
            2'd2:    return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // State register and registered status outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            busy    <= CLEAR_ON_RST;
            ready_q <= !CLEAR_ON_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == ST_CLEAR);
            ready_q <= (state_d == ST_RUN);
        end
    end

    // Next state: sweep one word per cycle, then run forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_c = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    assign a_ready = ready_q;
    assign b_ready = ready_q;

    // Per-port request decode. Rst gates acceptance for the no-clear build, whose
    // ready flop resets high.
    logic        a_acc_c, a_bad_c, a_wr_c, a_rd_c;
    logic        b_acc_c, b_bad_c, b_wr_c, b_rd_c;
    logic [3:0]  a_mask_c, b_mask_c;
    logic [31:0] a_raw_c, b_raw_c;

    assign a_acc_c  = a_req & ready_q & ~Rst;
    assign a_bad_c  = illegal(a_size, a_addr[1:0]);
    assign a_wr_c   = a_acc_c & ~a_bad_c & a_we;
    assign a_rd_c   = a_acc_c & ~a_bad_c & ~a_we;
    assign a_mask_c = lane_mask(a_size);

    assign b_acc_c  = b_req & ready_q & ~Rst;
    assign b_bad_c  = illegal(b_size, b_addr[1:0]);
    assign b_wr_c   = b_acc_c & ~b_bad_c & b_we;
    assign b_rd_c   = b_acc_c & ~b_bad_c & ~b_we;
    assign b_mask_c = lane_mask(b_size);

    // Raw 4-byte windows; addresses wrap modulo the array size.
    always_comb begin
        a_raw_c = '0;
        b_raw_c = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            a_raw_c[8*k +: 8] = mem[a_addr + ADDR_W'(k)];
            b_raw_c[8*k +: 8] = mem[b_addr + ADDR_W'(k)];
        end
    end

    // Array writes. Port A is applied after port B so it wins on shared bytes.
    always_ff @(posedge Clk) begin
        if (clear_c) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem[{cnt_q, 2'(k)}] <= 8'h00;
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            if (b_wr_c && b_mask_c[k]) begin
                mem[b_addr + ADDR_W'(k)] <= b_wdata[8*k +: 8];
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            if (a_wr_c && a_mask_c[k]) begin
                mem[a_addr + ADDR_W'(k)] <= a_wdata[8*k +: 8];
            end
        end
    end

    // Port A response; reads see pre-edge contents.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_rvalid <= 1'b0;
            a_err    <= 1'b0;
            a_rdata  <= '0;
        end else begin
            a_rvalid <= a_rd_c;
            a_err    <= a_acc_c & a_bad_c;
            if (a_rd_c) begin
                a_rdata <= extend(a_raw_c, a_size, a_signed);
            end
        end
    end

    // Port B response.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;
            b_rdata  <= '0;
        end else begin
            b_rvalid <= b_rd_c;
            b_err    <= b_acc_c & b_bad_c;
            if (b_rd_c) begin
                b_rdata <= extend(b_raw_c, b_size, b_signed);
            end
        end
    end

endmodule

// File: tb/tb_dual_port_byte_mem.sv
// Bench for dual_port_byte_mem. Instance 0: ADDR_W=8 with clear sweep and alignment
// checking. Instance 1: ADDR_W=16 with no clear and no alignment checking.
// Index convention for the signal arrays is [instance][port], port 0 = A, 1 = B.
module tb_dual_port_byte_mem;

    logic        clk;
    logic        rst    [2];
    logic        req    [2][2];
    logic        we     [2][2];
    logic [1:0]  size   [2][2];
    logic        sgn    [2][2];
    logic [7:0]  addr8  [2];
    logic [15:0] addr16 [2];
    logic [31:0] wdata  [2][2];
    logic        busy   [2];
    logic        ready  [2][2];
    logic        rvalid [2][2];
    logic [31:0] rdata  [2][2];
    logic        err    [2][2];

    int n_total = 0;
    int n_pass  = 0;

    dual_port_byte_mem #(.ADDR_W(8), .CLEAR_ON_RST(1'b1), .ALIGN_CHECK(1'b1)) u_dut8 (
        .Clk(clk), .Rst(rst[0]), .busy(busy[0]),
        .a_req(req[0][0]), .a_we(we[0][0]), .a_size(size[0][0]), .a_signed(sgn[0][0]),
        .a_addr(addr8[0]), .a_wdata(wdata[0][0]), .a_ready(ready[0][0]),
        .a_rvalid(rvalid[0][0]), .a_rdata(rdata[0][0]), .a_err(err[0][0]),
        .b_req(req[0][1]), .b_we(we[0][1]), .b_size(size[0][1]), .b_signed(sgn[0][1]),
        .b_addr(addr8[1]), .b_wdata(wdata[0][1]), .b_ready(ready[0][1]),
        .b_rvalid(rvalid[0][1]), .b_rdata(rdata[0][1]), .b_err(err[0][1])
    );

    dual_port_byte_mem #(.ADDR_W(16), .CLEAR_ON_RST(1'b0), .ALIGN_CHECK(1'b0)) u_dut16 (
        .Clk(clk), .Rst(rst[1]), .busy(busy[1]),
        .a_req(req[1][0]), .a_we(we[1][0]), .a_size(size[1][0]), .a_signed(sgn[1][0]),
        .a_addr(addr16[0]), .a_wdata(wdata[1][0]), .a_ready(ready[1][0]),
        .a_rvalid(rvalid[1][0]), .a_rdata(rdata[1][0]), .a_err(err[1][0]),
        .b_req(req[1][1]), .b_we(we[1][1]), .b_size(size[1][1]), .b_signed(sgn[1][1]),
        .b_addr(addr16[1]), .b_wdata(wdata[1][1]), .b_ready(ready[1][1]),
        .b_rvalid(rvalid[1][1]), .b_rdata(rdata[1][1]), .b_err(err[1][1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference byte array for instance 0 and the rdata each of its ports should hold.
    bit [7:0]  m8   [256];
    bit [31:0] hold [2];

    typedef struct {
        int        port;
        bit        we;
        bit [1:0]  size;
        bit        sgn;
        int        addr;
        bit [31:0] wdata;
        bit        e_err;
        bit        e_rv;
        bit [31:0] e_rdata;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int inst, input int p, input bit r, input bit w,
                         input bit [1:0] sz, input bit s, input int a, input bit [31:0] d);
        req[inst][p]   = r;
        we[inst][p]    = w;
        size[inst][p]  = sz;
        sgn[inst][p]   = s;
        wdata[inst][p] = d;
        if (inst == 0) addr8[p] = a[7:0];
        else           addr16[p] = a[15:0];
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                drive(i, p, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0);
    endtask

    function automatic int nbytes(input bit [1:0] sz);
        return (sz == 2'd3) ? 4 : int'(sz);
    endfunction

    function automatic bit mlegal(input int a, input bit [1:0] sz);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd2 && (a % 2) != 0) return 1'b0;
        if (sz == 2'd3 && (a % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Little-endian gather with modulo-256 addresses, then arithmetic extension.
    function automatic bit [31:0] mread(input int a, input bit [1:0] sz, input bit s);
        int n = nbytes(sz);
        bit [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) v |= 32'(m8[(a + k) % 256]) << (8 * k);
        if (n < 4 && s && v[8*n-1]) v |= ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    function automatic void mwrite(input int a, input bit [1:0] sz, input bit [31:0] d);
        for (int k = 0; k < nbytes(sz); k++) m8[(a + k) % 256] = 8'(d >> (8 * k));
    endfunction

    initial begin
        int n;
        tbl[0]  = '{0, 1'b1, 2'd3, 1'b0, 'h10, 32'h80FF7F01, 1'b0, 1'b0, 32'h00000000};
        tbl[1]  = '{1, 1'b0, 2'd1, 1'b1, 'h10, 32'h0,        1'b0, 1'b1, 32'h00000001};
        tbl[2]  = '{1, 1'b0, 2'd2, 1'b1, 'h10, 32'h0,        1'b0, 1'b1, 32'h00007F01};
        tbl[3]  = '{1, 1'b0, 2'd2, 1'b1, 'h12, 32'h0,        1'b0, 1'b1, 32'hFFFF80FF};
        tbl[4]  = '{1, 1'b0, 2'd1, 1'b0, 'h13, 32'h0,        1'b0, 1'b1, 32'h00000080};
        tbl[5]  = '{1, 1'b0, 2'd1, 1'b1, 'h13, 32'h0,        1'b0, 1'b1, 32'hFFFFFF80};
        tbl[6]  = '{1, 1'b0, 2'd3, 1'b1, 'h10, 32'h0,        1'b0, 1'b1, 32'h80FF7F01};
        tbl[7]  = '{0, 1'b0, 2'd3, 1'b0, 'h10, 32'h0,        1'b0, 1'b1, 32'h80FF7F01};
        tbl[8]  = '{0, 1'b0, 2'd3, 1'b0, 'h11, 32'h0,        1'b1, 1'b0, 32'h80FF7F01};
        tbl[9]  = '{0, 1'b0, 2'd3, 1'b0, 'h12, 32'h0,        1'b1, 1'b0, 32'h80FF7F01};
        tbl[10] = '{0, 1'b0, 2'd2, 1'b0, 'h11, 32'h0,        1'b1, 1'b0, 32'h80FF7F01};
        tbl[11] = '{0, 1'b0, 2'd1, 1'b0, 'h11, 32'h0,        1'b0, 1'b1, 32'h0000007F};
        tbl[12] = '{0, 1'b0, 2'd0, 1'b0, 'h10, 32'h0,        1'b1, 1'b0, 32'h0000007F};
        tbl[13] = '{0, 1'b1, 2'd0, 1'b0, 'h10, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0000007F};
        tbl[14] = '{1, 1'b0, 2'd3, 1'b0, 'h10, 32'h0,        1'b0, 1'b1, 32'h80FF7F01};
        tbl[15] = '{0, 1'b1, 2'd2, 1'b0, 'h12, 32'h0000BEEF, 1'b0, 1'b0, 32'h0000007F};
        tbl[16] = '{0, 1'b1, 2'd2, 1'b0, 'h13, 32'h00001234, 1'b1, 1'b0, 32'h0000007F};
        tbl[17] = '{1, 1'b0, 2'd3, 1'b0, 'h10, 32'h0,        1'b0, 1'b1, 32'hBEEF7F01};
        tbl[18] = '{1, 1'b0, 2'd2, 1'b0, 'h12, 32'h0,        1'b0, 1'b1, 32'h0000BEEF};
        tbl[19] = '{0, 1'b0, 2'd2, 1'b1, 'h12, 32'h0,        1'b0, 1'b1, 32'hFFFFBEEF};
        tbl[20] = '{0, 1'b1, 2'd1, 1'b0, 'hFF, 32'h123456C3, 1'b0, 1'b0, 32'hFFFFBEEF};
        tbl[21] = '{1, 1'b0, 2'd1, 1'b1, 'hFF, 32'h0,        1'b0, 1'b1, 32'hFFFFFFC3};
        tbl[22] = '{1, 1'b0, 2'd3, 1'b0, 'hFC, 32'h0,        1'b0, 1'b1, 32'hC3000000};
        tbl[23] = '{1, 1'b1, 2'd3, 1'b0, 'h15, 32'hDEADBEEF, 1'b1, 1'b0, 32'hC3000000};

        // Reset state
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        idle();
        @(negedge clk);
        check("rst8_state", 64'({busy[0], ready[0][0], ready[0][1], rvalid[0][0], rvalid[0][1],
                                 err[0][0], err[0][1]}), 64'(7'b1000000));
        check("rst8_rdata", 64'({rdata[0][0], rdata[0][1]}), 64'h0);
        check("rst16_state", 64'({busy[1], ready[1][0], ready[1][1], rvalid[1][0], err[1][0]}),
              64'(5'b01100));
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Clear sweep length and cleared contents
        n = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            n++;
            if (!busy[0]) break;
        end
        check("t1_busy_cycles", 64'(n), 64'(64));
        check("t1_ready", 64'({ready[0][0], ready[0][1]}), 64'(2'b11));
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, 1'b1, 1'b0, 2'd3, 1'b0, 4 * i, 32'h0);
            step();
            check($sformatf("t1_zero_%0h", 4 * i), 64'({rvalid[0][0], rdata[0][0]}),
                  64'({1'b1, 32'h0}));
        end
        idle();

        // Table-driven single-port accesses
        for (int i = 0; i < NV; i++) begin
            drive(0, tbl[i].port, 1'b1, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr,
                  tbl[i].wdata);
            step();
            idle();
            check($sformatf("vec%0d", i),
                  64'({err[0][tbl[i].port], rvalid[0][tbl[i].port], rdata[0][tbl[i].port]}),
                  64'({tbl[i].e_err, tbl[i].e_rv, tbl[i].e_rdata}));
            check($sformatf("vec%0d_other", i),
                  64'({err[0][1-tbl[i].port], rvalid[0][1-tbl[i].port]}), 64'(2'b00));
        end

        // Same-edge collisions
        drive(0, 0, 1'b1, 1'b1, 2'd1, 1'b0, 'h20, 32'h000000AA);
        drive(0, 1, 1'b1, 1'b1, 2'd2, 1'b0, 'h20, 32'h00005511);
        step();
        drive(0, 0, 1'b1, 1'b1, 2'd3, 1'b0, 'h28, 32'h11111111);
        drive(0, 1, 1'b1, 1'b1, 2'd3, 1'b0, 'h28, 32'h22222222);
        step();
        idle();
        drive(0, 0, 1'b1, 1'b0, 2'd3, 1'b0, 'h20, 32'h0);
        drive(0, 1, 1'b1, 1'b0, 2'd3, 1'b0, 'h28, 32'h0);
        step();
        check("t4_byte_vs_half", 64'(rdata[0][0]), 64'h000055AA);
        check("t4_word_a_wins", 64'(rdata[0][1]), 64'h11111111);
        drive(0, 0, 1'b1, 1'b1, 2'd3, 1'b0, 'h24, 32'h11223344);
        drive(0, 1, 1'b1, 1'b0, 2'd3, 1'b0, 'h24, 32'h0);
        step();
        check("t4_b_old_data", 64'({rvalid[0][1], rdata[0][1]}), 64'({1'b1, 32'h0}));
        drive(0, 0, 1'b1, 1'b0, 2'd3, 1'b0, 'h24, 32'h0);
        drive(0, 1, 1'b1, 1'b1, 2'd1, 1'b0, 'h24, 32'h00000099);
        step();
        check("t4_a_old_data", 64'({rvalid[0][0], rdata[0][0]}), 64'({1'b1, 32'h11223344}));
        idle();
        drive(0, 1, 1'b1, 1'b0, 2'd3, 1'b0, 'h24, 32'h0);
        step();
        idle();
        check("t4_b_new_data", 64'(rdata[0][1]), 64'h11223399);

        // Address wrap and misaligned access with checking disabled
        drive(1, 0, 1'b1, 1'b1, 2'd3, 1'b0, 'hFFFE, 32'hCAFEBABE);
        step();
        check("t3_wrap_write", 64'({err[1][0], rvalid[1][0]}), 64'(2'b00));
        begin
            int        wa [4] = '{'hFFFE, 'hFFFF, 'h0000, 'h0001};
            bit [31:0] wb [4] = '{32'hBE, 32'hBA, 32'hFE, 32'hCA};
            for (int i = 0; i < 4; i++) begin
                drive(1, 1, 1'b1, 1'b0, 2'd1, 1'b0, wa[i], 32'h0);
                step();
                check($sformatf("t3_wrap_byte_%0h", wa[i]),
                      64'({err[1][1], rvalid[1][1], rdata[1][1]}), 64'({2'b01, wb[i]}));
            end
        end
        drive(1, 1, 1'b1, 1'b0, 2'd3, 1'b0, 'hFFFE, 32'h0);
        drive(1, 0, 1'b1, 1'b0, 2'd2, 1'b1, 'hFFFF, 32'h0);
        step();
        check("t3_wrap_word", 64'({err[1][1], rvalid[1][1], rdata[1][1]}),
              64'({2'b01, 32'hCAFEBABE}));
        check("t3_wrap_half_s", 64'({err[1][0], rvalid[1][0], rdata[1][0]}),
              64'({2'b01, 32'hFFFFFEBA}));
        drive(1, 0, 1'b1, 1'b0, 2'd0, 1'b0, 'h0000, 32'h0);
        drive(1, 1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0);
        step();
        idle();
        check("t3_size0_nocheck", 64'({err[1][0], rvalid[1][0], rdata[1][0]}),
              64'({2'b10, 32'hFFFFFEBA}));

        // Reset kills a pending rvalid, then reset mid-sweep restarts the clear
        drive(0, 0, 1'b1, 1'b0, 2'd3, 1'b0, 'h20, 32'h0);
        step();
        check("t5_pre_read", 64'({rvalid[0][0], rdata[0][0]}), 64'({1'b1, 32'h000055AA}));
        rst[0] = 1'b1;
        #1;
        check("t5_rst_kills", 64'({rvalid[0][0], rdata[0][0], busy[0], ready[0][0]}),
              64'({1'b0, 32'h0, 2'b10}));
        drive(0, 1, 1'b1, 1'b1, 2'd3, 1'b0, 'h40, 32'hFFFFFFFF);
        @(negedge clk);
        rst[0] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            check("t5_busy_ignore", 64'({busy[0], rvalid[0][0], err[0][0], rvalid[0][1],
                                         err[0][1]}), 64'(5'b10000));
        end
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            n++;
            if (!busy[0]) break;
            if ({rvalid[0][0], err[0][0], rvalid[0][1], err[0][1]} != 4'b0000) begin
                check("t5_busy_quiet", 64'({rvalid[0][0], err[0][0], rvalid[0][1], err[0][1]}),
                      64'(4'b0000));
            end
        end
        idle();
        check("t5_restart_cycles", 64'(n), 64'(64));
        check("t5_quiet_at_ready", 64'({ready[0][0], rvalid[0][0], err[0][0], rvalid[0][1],
                                        err[0][1]}), 64'(5'b10000));
        drive(0, 0, 1'b1, 1'b0, 2'd3, 1'b0, 'h20, 32'h0);
        drive(0, 1, 1'b1, 1'b0, 2'd3, 1'b0, 'h40, 32'h0);
        step();
        idle();
        check("t5_recleared", 64'({rdata[0][0], rdata[0][1]}), 64'h0);

        // Random traffic on both ports against the reference array
        for (int i = 0; i < 256; i++) m8[i] = 8'h00;
        hold[0] = 32'h0;
        hold[1] = 32'h0;
        for (int c = 0; c < 1500; c++) begin
            bit        r [2];
            bit        w [2];
            bit [1:0]  sz [2];
            bit        s [2];
            int        a [2];
            bit [31:0] d [2];
            bit        e_rv [2];
            bit        e_er [2];
            for (int p = 0; p < 2; p++) begin
                r[p]  = ($urandom_range(0, 3) != 0);
                w[p]  = 1'($urandom_range(0, 1));
                sz[p] = 2'($urandom_range(0, 3));
                s[p]  = 1'($urandom_range(0, 1));
                a[p]  = int'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) a[p] = a[p] - (a[p] % ((sz[p] == 2'd3) ? 4 : 2));
                if ($urandom_range(0, 1) != 0) a[p] = a[p] % 16;
                d[p]  = $urandom;
                drive(0, p, r[p], w[p], sz[p], s[p], a[p], d[p]);
                e_rv[p] = r[p] && mlegal(a[p], sz[p]) && !w[p];
                e_er[p] = r[p] && !mlegal(a[p], sz[p]);
                if (e_rv[p]) hold[p] = mread(a[p], sz[p], s[p]);
            end
            if (r[1] && w[1] && mlegal(a[1], sz[1])) mwrite(a[1], sz[1], d[1]);
            if (r[0] && w[0] && mlegal(a[0], sz[0])) mwrite(a[0], sz[0], d[0]);
            step();
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rand%0d_p%0d", c, p),
                      64'({rvalid[0][p], err[0][p], rdata[0][p]}),
                      64'({e_rv[p], e_er[p], hold[p]}));
            end
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
